crossing_scheduler: RTL and testbench
=====================================

Name: crossing_scheduler

Overview:
- Phase scheduler for a 4-approach intersection with one exclusive pedestrian phase.
- Latches vehicle detector requests and pedestrian button presses.
- Shares the crossing among requesters: round-robin between approaches, with the pedestrian phase interleaved.
- Sequences green -> yellow -> all-red -> next phase on a prescaled time base. Drives the signal-head lamp outputs directly.

Parameters:
- N_APP, 4, number of vehicle approaches (2..8)
- TICK_DIV, 1000, clk cycles per timing tick
- T_ALLRED, 2, all-red clearance, in ticks
- T_GREEN_MIN, 10, minimum vehicle green, in ticks
- T_GREEN_MAX, 40, maximum vehicle green, in ticks
- T_YELLOW, 5, vehicle yellow, in ticks
- T_WALK, 20, pedestrian walk phase, in ticks

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- veh_req  in  N_APP  vehicle detector per approach, level
- ped_btn  in  1  pedestrian button, any-length pulse
- veh_green  out  N_APP  green lamp, one-hot or zero
- veh_yellow  out  N_APP  yellow lamp, one-hot or zero
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  pedestrian request latched, not yet served
- phase  out  3  current state code: ALLRED=0, GREEN=1, YELLOW=2, WALK=3

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset (async, immediate):
  - state=ALLRED, all outputs 0.
  - pend_veh=0, ped_pending=0.
  - rr_ptr=N_APP-1, so approach 0 has first priority.
  - last_walk=0.
  - Prescaler and tick timer both 0.
- Time base:
  - Prescaler counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1.
  - Tick timer increments on tick and saturates at its maximum width.
  - Prescaler and timer clear on every state transition, so a T-tick state lasts exactly T*TICK_DIV cycles.
- Request latching:
  - pend_veh[i] sets while veh_req[i]=1 and clears in the cycle approach i enters GREEN. On same-cycle set and clear, clear wins.
  - ped_pending sets on ped_btn=1 in any state except WALK, and clears on WALK entry. Presses during WALK are ignored.
- ALLRED (all lamps off / red):
  - Arbitrate once timer>=T_ALLRED.
  - If ped_pending=1 and last_walk=0 -> WALK.
  - Else if any pend_veh -> GREEN for the first set bit searching from rr_ptr+1 with wrap; set rr_ptr to that index and last_walk=0.
  - Else if ped_pending=1 -> WALK.
  - Else remain in ALLRED indefinitely (timer saturates); arbitrate every cycle thereafter.
- GREEN(i): veh_green[i]=1. Go to YELLOW(i) when either:
  - timer>=T_GREEN_MAX, even if nothing else is pending, or
  - timer>=T_GREEN_MIN and (veh_req[i]=0, or pend_veh has another bit set, or ped_pending=1).
- YELLOW(i): veh_yellow[i]=1. After T_YELLOW ticks -> ALLRED.
- WALK: walk=1, last_walk=1. After T_WALK ticks -> ALLRED.
- Output invariants:
  - At most one lamp bit among veh_green, veh_yellow and walk is active at a time.
  - Outputs are registered: they change one cycle after the state-transition decision.
- Arithmetic:
  - Timer width is clog2(max of all T_*)+1.
  - Prescaler width is clog2(TICK_DIV).
  - Comparisons are unsigned.
- Reset mid-phase: lamps drop to 0 immediately and the full reset sequence restarts on release.

Test Plan:
(Parameters for all scenarios: TICK_DIV=4, T_ALLRED=2, T_GREEN_MIN=3, T_GREEN_MAX=6, T_YELLOW=2, T_WALK=4.)
1. Release reset with veh_req=0001 held:
   - 8 cycles all-red, then veh_green=0001 for 24 cycles (max), yellow 8, all-red 8, green 0001 again.
2. veh_req=1111 held:
   - Greens served in order 0,1,2,3,0, each exactly 12 cycles (min, others pending).
   - Each green is separated by 8 yellow + 8 all-red cycles.
3. veh_req=0011 held, 1-cycle ped_btn during green of approach 1:
   - ped_pending=1 next cycle; green 1 ends at min.
   - Then yellow -> all-red -> walk=1 for 16 cycles, ped_pending=0 on walk entry.
   - Next phase is green 0.
4. ped_btn held through WALK and beyond, veh_req=0100:
   - After WALK, green 2 is served before the second WALK (last_walk rule).
   - Presses during WALK do not set ped_pending.
5. No requests for 1000 cycles after reset:
   - phase=0 and all lamps 0 throughout.
   - Then veh_req[3] pulse for 1 cycle -> green 3 starts next cycle; it ends at min since veh_req[3]=0.
6. Assert rst_n=0 mid-green 2:
   - Lamps=0 in the same cycle; pend_veh and ped_pending cleared.
   - After release, sequence restarts with 8-cycle all-red and approach 0 first priority.

Source files
------------

// File: rtl/crossing_scheduler.sv
// Phase scheduler for a multi-approach intersection with an exclusive pedestrian phase.
// Round-robin vehicle service, interleaved walk phase, prescaled green/yellow/all-red timing.
module crossing_scheduler #(
   parameter int unsigned N_APP       = 4,
   parameter int unsigned TICK_DIV    = 1000,
   parameter int unsigned T_ALLRED    = 2,
   parameter int unsigned T_GREEN_MIN = 10,
   parameter int unsigned T_GREEN_MAX = 40,
   parameter int unsigned T_YELLOW    = 5,
   parameter int unsigned T_WALK      = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_APP-1:0] veh_req,
   input  logic             ped_btn,
   output logic [N_APP-1:0] veh_green,
   output logic [N_APP-1:0] veh_yellow,
   output logic             walk,
   output logic             ped_pending,
   output logic [2:0]       phase
);

   localparam int unsigned T_MAX_A = (T_ALLRED > T_YELLOW) ? T_ALLRED : T_YELLOW;
   localparam int unsigned T_MAX_B = (T_GREEN_MAX > T_WALK) ? T_GREEN_MAX : T_WALK;
   localparam int unsigned T_MAX_C = (T_MAX_A > T_GREEN_MIN) ? T_MAX_A : T_GREEN_MIN;
   localparam int unsigned T_MAX   = (T_MAX_B > T_MAX_C) ? T_MAX_B : T_MAX_C;
   localparam int unsigned TW      = $clog2(T_MAX) + 1;
   localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned IW      = (N_APP > 1) ? $clog2(N_APP) : 1;

   localparam logic [TW-1:0] TC_ALLRED = TW'(T_ALLRED);
   localparam logic [TW-1:0] TC_GMIN   = TW'(T_GREEN_MIN);
   localparam logic [TW-1:0] TC_GMAX   = TW'(T_GREEN_MAX);
   localparam logic [TW-1:0] TC_YELLOW = TW'(T_YELLOW);
   localparam logic [TW-1:0] TC_WALK   = TW'(T_WALK);

   typedef enum logic [2:0] {
      S_ALLRED = 3'd0,
      S_GREEN  = 3'd1,
      S_YELLOW = 3'd2,
      S_WALK   = 3'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q;
   logic [TW-1:0]    timer_q;
   logic [TW-1:0]    timer_inc;
   logic             tick;
   logic [N_APP-1:0] pend_veh_q;
   logic [IW-1:0]    rr_ptr_q;
   logic [IW-1:0]    cur_q;
   logic             last_walk_q;

   logic             arb_found;
   logic [IW-1:0]    arb_idx;
   logic [N_APP-1:0] arb_oh;
   logic [N_APP-1:0] cur_oh;
   logic [N_APP-1:0] nxt_oh;
   logic             enter_green;
   logic             enter_walk;
   logic             trans;

   assign tick = (presc_q == PW'(TICK_DIV - 1));

   // Timer value including this cycle's tick, so a T-tick phase ends on its last cycle
   // rather than one cycle late.
   assign timer_inc = (tick && !(&timer_q)) ? timer_q + TW'(1) : timer_q;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int unsigned k = 1; k <= N_APP; k++) begin
         if (!arb_found && pend_veh_q[IW'((32'(rr_ptr_q) + k) % N_APP)]) begin
            arb_found = 1'b1;
            arb_idx   = IW'((32'(rr_ptr_q) + k) % N_APP);
         end
      end
   end

   always_comb begin
      arb_oh = '0;
      cur_oh = '0;
      for (int unsigned i = 0; i < N_APP; i++) begin
         arb_oh[i] = arb_found && (arb_idx == IW'(i));
         cur_oh[i] = (cur_q == IW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ALLRED: begin
            if (timer_inc >= TC_ALLRED) begin
               if (ped_pending && !last_walk_q) state_d = S_WALK;
               else if (arb_found)              state_d = S_GREEN;
               else if (ped_pending)            state_d = S_WALK;
            end
         end
         S_GREEN: begin
            if ((timer_inc >= TC_GMAX) ||
                ((timer_inc >= TC_GMIN) &&
                 (!(|(veh_req & cur_oh)) || (|(pend_veh_q & ~cur_oh)) || ped_pending)))
               state_d = S_YELLOW;
         end
         S_YELLOW: begin
            if (timer_inc >= TC_YELLOW) state_d = S_ALLRED;
         end
         S_WALK: begin
            if (timer_inc >= TC_WALK) state_d = S_ALLRED;
         end
         default: state_d = S_ALLRED;
      endcase
   end

   assign trans       = (state_d != state_q);
   assign enter_green = (state_q == S_ALLRED) && (state_d == S_GREEN);
   assign enter_walk  = (state_q != S_WALK) && (state_d == S_WALK);
   assign nxt_oh      = enter_green ? arb_oh : cur_oh;
   assign phase       = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_ALLRED;
         presc_q     <= '0;
         timer_q     <= '0;
         pend_veh_q  <= '0;
         ped_pending <= 1'b0;
         rr_ptr_q    <= IW'(N_APP - 1);
         cur_q       <= '0;
         last_walk_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (trans || tick) presc_q <= '0;
         else               presc_q <= presc_q + PW'(1);
         timer_q <= trans ? '0 : timer_inc;
         // Grant clear wins over a simultaneous detector set for the same approach.
         pend_veh_q <= (pend_veh_q | veh_req) & ~(enter_green ? arb_oh : '0);
         if (enter_walk)                           ped_pending <= 1'b0;
         else if (ped_btn && state_q != S_WALK)    ped_pending <= 1'b1;
         if (enter_green) begin
            rr_ptr_q    <= arb_idx;
            cur_q       <= arb_idx;
            last_walk_q <= 1'b0;
         end else if (enter_walk) begin
            last_walk_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         veh_green  <= '0;
         veh_yellow <= '0;
         walk       <= 1'b0;
      end else begin
         veh_green  <= (state_d == S_GREEN)  ? nxt_oh : '0;
         veh_yellow <= (state_d == S_YELLOW) ? cur_oh : '0;
         walk       <= (state_d == S_WALK);
      end
   end

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler: cycle-count phase model plus literal phase sequences.
module tb_crossing_scheduler;

   localparam int DIV  = 4;
   localparam int TA   = 2;
   localparam int GMIN = 3;
   localparam int GMAX = 6;
   localparam int TY   = 2;
   localparam int TWK  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] veh_req = 4'd0;
   logic       ped_btn = 1'b0;
   logic [3:0] veh_green, veh_yellow;
   logic       walk, ped_pending;
   logic [2:0] phase;

   int vectors = 0;
   int miscompares = 0;

   crossing_scheduler #(
      .N_APP(4), .TICK_DIV(DIV), .T_ALLRED(TA), .T_GREEN_MIN(GMIN),
      .T_GREEN_MAX(GMAX), .T_YELLOW(TY), .T_WALK(TWK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .veh_req(veh_req), .ped_btn(ped_btn),
      .veh_green(veh_green), .veh_yellow(veh_yellow), .walk(walk),
      .ped_pending(ped_pending), .phase(phase)
   );

   always #5 clk = ~clk;

   // Model: phase plus cycles spent in it; phase ends once T*DIV cycles have elapsed.
   int       m_phase = 0, m_cnt = 0, m_cur = 0, m_rr = 3;
   bit [3:0] m_pend = 4'd0;
   bit       m_ped = 1'b0, m_lastw = 1'b0;

   function automatic bit done(input int cnt, input int t);
      return (cnt + 1) >= t * DIV;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int       nxt, sel, j;
      bit       other;
      bit [3:0] pend_n;
      if (!rst_n) begin
         m_phase <= 0; m_cnt <= 0; m_cur <= 0; m_rr <= 3;
         m_pend <= 4'd0; m_ped <= 1'b0; m_lastw <= 1'b0;
      end else begin
         nxt = m_phase;
         sel = -1;
         case (m_phase)
            0: if (done(m_cnt, TA)) begin
                  if (m_ped && !m_lastw) nxt = 3;
                  else begin
                     for (int k = 1; k <= 4; k++) begin
                        j = (m_rr + k) % 4;
                        if (sel < 0 && ((m_pend >> j) & 4'd1) != 0) sel = j;
                     end
                     if (sel >= 0) nxt = 1;
                     else if (m_ped) nxt = 3;
                  end
               end
            1: begin
                  other = (m_pend & ~(4'd1 << m_cur)) != 0;
                  if (done(m_cnt, GMAX) ||
                      (done(m_cnt, GMIN) && (((veh_req >> m_cur) & 4'd1) == 0 || other || m_ped)))
                     nxt = 2;
               end
            2: if (done(m_cnt, TY))  nxt = 0;
            default: if (done(m_cnt, TWK)) nxt = 0;
         endcase
         pend_n = m_pend | veh_req;
         if (m_phase == 0 && nxt == 1) begin
            pend_n = pend_n & ~(4'd1 << sel);
            m_cur <= sel;
            m_rr <= sel;
            m_lastw <= 1'b0;
         end
         if (m_phase != 3 && nxt == 3) begin
            m_ped <= 1'b0;
            m_lastw <= 1'b1;
         end else if (ped_btn && m_phase != 3) m_ped <= 1'b1;
         m_pend <= pend_n;
         m_cnt <= (nxt != m_phase) ? 0 : m_cnt + 1;
         m_phase <= nxt;
      end
   end

   always @(negedge clk) begin
      logic [3:0] eg, ey;
      eg = (m_phase == 1) ? 4'(4'd1 << m_cur) : 4'd0;
      ey = (m_phase == 2) ? 4'(4'd1 << m_cur) : 4'd0;
      vectors++;
      if (veh_green !== eg || veh_yellow !== ey || walk !== (m_phase == 3) ||
          ped_pending !== m_ped || phase !== 3'(m_phase)) begin
         miscompares++;
         $display("FAIL model t=%0t: dut g=%b y=%b w=%b pp=%b ph=%0d, model g=%b y=%b w=%b pp=%b ph=%0d",
                  $time, veh_green, veh_yellow, walk, ped_pending, phase,
                  eg, ey, (m_phase == 3), m_ped, m_phase);
      end
   end

   task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] y,
                      input logic w, input logic pp, input logic [2:0] ph);
      vectors++;
      if (veh_green !== g || veh_yellow !== y || walk !== w || ped_pending !== pp || phase !== ph) begin
         miscompares++;
         $display("FAIL %s t=%0t: got g=%b y=%b w=%b pp=%b ph=%0d, want g=%b y=%b w=%b pp=%b ph=%0d",
                  nm, $time, veh_green, veh_yellow, walk, ped_pending, phase, g, y, w, pp, ph);
      end
   endtask

   task automatic run(input string nm, input logic [3:0] g, input logic [3:0] y,
                      input logic w, input logic pp, input logic [2:0] ph, input int n);
      repeat (n) begin
         @(negedge clk);
         chk(nm, g, y, w, pp, ph);
      end
   endtask

   task automatic do_reset(input logic [3:0] vr, input logic pb);
      #1 rst_n = 1'b0;
      veh_req = vr;
      ped_btn = pb;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic press_ped;
      #1 ped_btn = 1'b1;
      @(posedge clk);
      #1 ped_btn = 1'b0;
   endtask

   initial begin
      logic [3:0] oh;

      // 1: single approach held, green runs to max
      do_reset(4'b0001, 1'b0);
      run("s1_allred0", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s1_green0",  4'b0001, 4'b0000, 0, 0, 3'd1, 24);
      run("s1_yellow0", 4'b0000, 4'b0001, 0, 0, 3'd2, 8);
      run("s1_allred1", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s1_green0b", 4'b0001, 4'b0000, 0, 0, 3'd1, 1);

      // 2: all approaches held, round-robin at min green
      do_reset(4'b1111, 1'b0);
      run("s2_allred0", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      for (int i = 0; i < 4; i++) begin
         oh = 4'd1 << i;
         run("s2_green",  oh,      4'b0000, 0, 0, 3'd1, 12);
         run("s2_yellow", 4'b0000, oh,      0, 0, 3'd2, 8);
         run("s2_allred", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      end
      run("s2_wrap0", 4'b0001, 4'b0000, 0, 0, 3'd1, 1);

      // 3: pedestrian press during green 1
      do_reset(4'b0011, 1'b0);
      run("s3_allred0", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s3_green0",  4'b0001, 4'b0000, 0, 0, 3'd1, 12);
      run("s3_yellow0", 4'b0000, 4'b0001, 0, 0, 3'd2, 8);
      run("s3_allred1", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s3_green1a", 4'b0010, 4'b0000, 0, 0, 3'd1, 3);
      press_ped();
      run("s3_green1b", 4'b0010, 4'b0000, 0, 1, 3'd1, 9);
      run("s3_yellow1", 4'b0000, 4'b0010, 0, 1, 3'd2, 8);
      run("s3_allred2", 4'b0000, 4'b0000, 0, 1, 3'd0, 8);
      run("s3_walk",    4'b0000, 4'b0000, 1, 0, 3'd3, 16);
      run("s3_allred3", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s3_green0b", 4'b0001, 4'b0000, 0, 0, 3'd1, 1);

      // 4: button held throughout; vehicle served between walks
      do_reset(4'b0100, 1'b1);
      run("s4_allred0a", 4'b0000, 4'b0000, 0, 0, 3'd0, 1);
      run("s4_allred0b", 4'b0000, 4'b0000, 0, 1, 3'd0, 7);
      run("s4_walk1",    4'b0000, 4'b0000, 1, 0, 3'd3, 16);
      run("s4_allred1a", 4'b0000, 4'b0000, 0, 0, 3'd0, 1);
      run("s4_allred1b", 4'b0000, 4'b0000, 0, 1, 3'd0, 7);
      run("s4_green2",   4'b0100, 4'b0000, 0, 1, 3'd1, 12);
      run("s4_yellow2",  4'b0000, 4'b0100, 0, 1, 3'd2, 8);
      run("s4_allred2",  4'b0000, 4'b0000, 0, 1, 3'd0, 8);
      run("s4_walk2",    4'b0000, 4'b0000, 1, 0, 3'd3, 16);
      #1 ped_btn = 1'b0;

      // 5: long idle, then a one-cycle detector pulse on approach 3
      do_reset(4'b0000, 1'b0);
      run("s5_idle", 4'b0000, 4'b0000, 0, 0, 3'd0, 1000);
      #1 veh_req = 4'b1000;
      @(posedge clk);
      #1 veh_req = 4'b0000;
      run("s5_latch",   4'b0000, 4'b0000, 0, 0, 3'd0, 1);
      run("s5_green3",  4'b1000, 4'b0000, 0, 0, 3'd1, 12);
      run("s5_yellow3", 4'b0000, 4'b1000, 0, 0, 3'd2, 8);
      run("s5_allred",  4'b0000, 4'b0000, 0, 0, 3'd0, 20);

      // 6: reset asserted mid-green
      do_reset(4'b0100, 1'b0);
      run("s6_allred0", 4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s6_green2a", 4'b0100, 4'b0000, 0, 0, 3'd1, 3);
      press_ped();
      run("s6_green2b", 4'b0100, 4'b0000, 0, 1, 3'd1, 3);
      #1 rst_n = 1'b0;
      veh_req = 4'b0000;
      #1 chk("s6_rst_now", 4'b0000, 4'b0000, 0, 0, 3'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      run("s6_cleared",  4'b0000, 4'b0000, 0, 0, 3'd0, 20);
      #1 veh_req = 4'b0101;
      run("s6_latch",    4'b0000, 4'b0000, 0, 0, 3'd0, 1);
      run("s6_green0",   4'b0001, 4'b0000, 0, 0, 3'd1, 12);
      run("s6_yellow0",  4'b0000, 4'b0001, 0, 0, 3'd2, 8);
      run("s6_allred1",  4'b0000, 4'b0000, 0, 0, 3'd0, 8);
      run("s6_green2",   4'b0100, 4'b0000, 0, 0, 3'd1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
